// File: rtl/cpu_pkg.sv
// Shared datapath constants and types for the CPU register file slice.
// Register 31 is the hardwired-zero register (XZR).
package cpu_pkg;

    localparam int DATA_W     = 64;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;
    localparam int ZERO_REG   = 31;

    typedef logic [DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/decoder_5to32.sv
// 5-to-32 one-hot decoder with enable.
// All outputs are low when the enable is low.
module decoder_5to32 (
    input  logic [4:0]  in_i,
    input  logic        en_i,
    output logic [31:0] out_o
);

    always_comb begin
        out_o = '0;
        if (en_i) begin
            out_o = 32'(1) << in_i;
        end
    end

endmodule

// File: rtl/regfile_32x64.sv
// 32 x 64 register file: two combinational read ports, one clocked write port.
// XZR (index 31) reads zero; same-cycle writes bypass to the read ports.
module regfile_32x64
    import cpu_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  reg_write,
    input  logic [REG_ADDR_W-1:0] write_reg,
    input  reg_data_t             write_data,
    input  logic [REG_ADDR_W-1:0] read_reg1,
    input  logic [REG_ADDR_W-1:0] read_reg2,
    output reg_data_t             read_data1,
    output reg_data_t             read_data2
);

    localparam logic [REG_ADDR_W-1:0] ZR = REG_ADDR_W'(ZERO_REG);

    logic                wr_en;
    logic [NUM_REGS-1:0] we;
    logic                we_unused;
    reg_data_t           rd_view [NUM_REGS];
    logic                byp1;
    logic                byp2;

    // Gating with rst_n drops writes and bypass while reset is held.
    assign wr_en = reg_write & rst_n;

    decoder_5to32 u_dec (
        .in_i  (write_reg),
        .en_i  (wr_en),
        .out_o (we)
    );

    assign we_unused = we[ZERO_REG];

    for (genvar i = 0; i < ZERO_REG; i++) begin : g_reg
        reg_data_t q;
        reg_data_t d;

        assign d = we[i] ? write_data : q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                q <= '0;
            end else begin
                q <= d;
            end
        end

        assign rd_view[i] = q;
    end

    assign rd_view[ZERO_REG] = '0;

    assign byp1 = wr_en && (write_reg == read_reg1);
    assign byp2 = wr_en && (write_reg == read_reg2);

    always_comb begin
        read_data1 = rd_view[read_reg1];
        if (read_reg1 == ZR) begin
            read_data1 = '0;
        end else if (byp1) begin
            read_data1 = write_data;
        end
    end

    always_comb begin
        read_data2 = rd_view[read_reg2];
        if (read_reg2 == ZR) begin
            read_data2 = '0;
        end else if (byp2) begin
            read_data2 = write_data;
        end
    end

endmodule

// File: tb/tb_regfile_32x64.sv
// Directed self-checking bench for regfile_32x64.
// Inputs change on the falling edge; outputs are sampled 1ns after changes.
module tb_regfile_32x64;

    logic        clk;
    logic        rst_n;
    logic        reg_write;
    logic [4:0]  write_reg;
    logic [63:0] write_data;
    logic [4:0]  read_reg1;
    logic [4:0]  read_reg2;
    logic [63:0] read_data1;
    logic [63:0] read_data2;

    int n_checks;
    int n_errors;

    regfile_32x64 dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .reg_write  (reg_write),
        .write_reg  (write_reg),
        .write_data (write_data),
        .read_reg1  (read_reg1),
        .read_reg2  (read_reg2),
        .read_data1 (read_data1),
        .read_data2 (read_data2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [4:0] idx, input logic [63:0] data);
        @(negedge clk);
        reg_write  = 1'b1;
        write_reg  = idx;
        write_data = data;
        @(posedge clk);
        #1;
        reg_write  = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a, input logic [4:0] b);
        read_reg1 = a;
        read_reg2 = b;
        #1;
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        rst_n      = 1'b0;
        reg_write  = 1'b0;
        write_reg  = '0;
        write_data = '0;
        read_reg1  = 5'd5;
        read_reg2  = 5'd0;

        repeat (2) @(posedge clk);
        #1;
        check("reset_p1", read_data1, 64'h0);
        check("reset_p2", read_data2, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Async reset clears a live register mid-cycle
        wr(5'd5, 64'hDEAD);
        rd(5'd5, 5'd5);
        check("x5_before_rst", read_data1, 64'hDEAD);
        #2;
        rst_n = 1'b0;
        #1;
        check("x5_async_rst", read_data1, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 32; i++) begin
            rd(5'(i), 5'(31 - i));
            check($sformatf("post_rst_p1_x%0d", i), read_data1, 64'h0);
        end

        // Basic write then read on both ports
        wr(5'd3, 64'h0123_4567_89AB_CDEF);
        rd(5'd3, 5'd3);
        check("x3_p1", read_data1, 64'h0123_4567_89AB_CDEF);
        check("x3_p2", read_data2, 64'h0123_4567_89AB_CDEF);
        rd(5'd2, 5'd4);
        check("x2_zero", read_data1, 64'h0);
        check("x4_zero", read_data2, 64'h0);

        // Zero register ignores writes and is never bypassed
        @(negedge clk);
        reg_write  = 1'b1;
        write_reg  = 5'd31;
        write_data = 64'hFFFF_FFFF_FFFF_FFFF;
        rd(5'd31, 5'd3);
        check("xzr_same_cycle", read_data1, 64'h0);
        check("xzr_x3_kept", read_data2, 64'h0123_4567_89AB_CDEF);
        @(posedge clk);
        #1;
        reg_write = 1'b0;
        #1;
        check("xzr_next_cycle", read_data1, 64'h0);
        check("xzr_x3_after", read_data2, 64'h0123_4567_89AB_CDEF);

        // Same-cycle bypass
        wr(5'd7, 64'h11);
        @(negedge clk);
        reg_write  = 1'b1;
        write_reg  = 5'd7;
        write_data = 64'h22;
        rd(5'd7, 5'd8);
        check("byp_p1", read_data1, 64'h22);
        check("byp_p2_x8", read_data2, 64'h0);
        @(posedge clk);
        #1;
        reg_write = 1'b0;
        #1;
        check("x7_stored", read_data1, 64'h22);

        // Disabled write: no storage change and no bypass
        @(negedge clk);
        reg_write  = 1'b0;
        write_reg  = 5'd9;
        write_data = 64'h55;
        rd(5'd9, 5'd9);
        check("dis_now", read_data1, 64'h0);
        for (int e = 0; e < 2; e++) begin
            @(posedge clk);
            #1;
            check($sformatf("dis_edge%0d", e), read_data1, 64'h0);
        end

        // Full sweep on both ports
        for (int i = 0; i < 31; i++) begin
            wr(5'(i), 64'(i) * 64'h1_0001);
        end
        @(negedge clk);
        for (int i = 0; i < 32; i++) begin
            rd(5'(i), 5'(31 - i));
            check($sformatf("sweep_p1_x%0d", i), read_data1,
                  (i == 31) ? 64'h0 : 64'(i) * 64'h1_0001);
            check($sformatf("sweep_p2_x%0d", 31 - i), read_data2,
                  (i == 0) ? 64'h0 : 64'(31 - i) * 64'h1_0001);
        end

        // Reset falling on the same edge as a write is dropped
        @(negedge clk);
        reg_write  = 1'b1;
        write_reg  = 5'd10;
        write_data = 64'hAA;
        rd(5'd10, 5'd11);
        check("x10_byp_pre_rst", read_data1, 64'hAA);
        @(posedge clk);
        rst_n = 1'b0;
        #1;
        check("x10_in_rst", read_data1, 64'h0);
        check("x11_in_rst", read_data2, 64'h0);
        @(negedge clk);
        reg_write = 1'b0;
        rst_n     = 1'b1;
        #1;
        check("x10_after_rst", read_data1, 64'h0);
        check("x11_after_rst", read_data2, 64'h0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
